// File: rtl/multi_flex_counter.sv
// NUM_CHANNELS independent up-counters with per-channel rollover, load, one-shot
// saturation and optional cascade from the next-lower channel (single-cycle ripple).
module multi_flex_counter #(
    parameter int NUM_CNT_BITS = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CHANNELS-1:0]              clear,
    input  logic [NUM_CHANNELS-1:0]              count_enable,
    input  logic [NUM_CHANNELS-1:0]              load,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val,
    input  logic [NUM_CHANNELS-1:0]              one_shot,
    input  logic [NUM_CHANNELS-1:0]              cascade_en,
    output logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CHANNELS-1:0]              rollover_flag,
    output logic [NUM_CHANNELS-1:0]              wrap_pulse,
    output logic [NUM_CHANNELS-1:0]              done
);

    localparam int W = NUM_CNT_BITS;
    localparam int N = NUM_CHANNELS;
    localparam logic [W-1:0] ONE = W'(1);

    logic [N*W-1:0] count_q, count_d;
    logic [N-1:0]   rollover_flag_q, rollover_flag_d;
    logic [N-1:0]   wrap_pulse_q, wrap_pulse_d;
    logic [N-1:0]   done_q, done_d;
    logic [N-1:0]   eff_en;
    logic [N-1:0]   wrap_ev;
    logic [W-1:0]   cur;
    logic [W-1:0]   nxt;
    logic [W-1:0]   rv;
    logic           prev_wrap;

    // Channels are evaluated low to high so a cascade sees the lower channel's
    // wrap decision from this same cycle.
    always_comb begin
        count_d         = count_q;
        rollover_flag_d = '0;
        done_d          = '0;
        wrap_pulse_d    = '0;
        wrap_ev         = '0;
        eff_en          = '0;
        cur             = '0;
        nxt             = '0;
        rv              = '0;
        prev_wrap       = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur       = count_q[i*W +: W];
            rv        = rollover_val[i*W +: W];
            eff_en[i] = count_enable[i] & ((i == 0) | ~cascade_en[i] | prev_wrap);
            nxt       = cur;
            if (clear[i]) begin
                nxt = '0;
            end else if (load[i]) begin
                nxt = load_val[i*W +: W];
            end else if (eff_en[i] && (rv != '0)) begin
                if (cur < rv) begin
                    nxt = cur + ONE;
                end else if (!one_shot[i]) begin
                    nxt        = ONE;
                    wrap_ev[i] = 1'b1;
                end
            end
            count_d[i*W +: W]  = nxt;
            rollover_flag_d[i] = (nxt == rv) && (rv != '0);
            done_d[i]          = one_shot[i] && (rv != '0) && (nxt >= rv);
            prev_wrap          = wrap_ev[i];
        end
        wrap_pulse_d = wrap_ev;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_q[gi*W +: W]  <= '0;
                    rollover_flag_q[gi] <= 1'b0;
                    wrap_pulse_q[gi]    <= 1'b0;
                    done_q[gi]          <= 1'b0;
                end else begin
                    count_q[gi*W +: W]  <= count_d[gi*W +: W];
                    rollover_flag_q[gi] <= rollover_flag_d[gi];
                    wrap_pulse_q[gi]    <= wrap_pulse_d[gi];
                    done_q[gi]          <= done_d[gi];
                end
            end
        end
    endgenerate

    assign count_out     = count_q;
    assign rollover_flag = rollover_flag_q;
    assign wrap_pulse    = wrap_pulse_q;
    assign done          = done_q;

endmodule

// File: tb/tb_multi_flex_counter.sv
// Directed bench for multi_flex_counter: default 8x4 instance plus 4x1 and 8x6
// instances for the parametrised wrap and packed-bus isolation checks.
module tb_multi_flex_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  clear, count_enable, load, one_shot, cascade_en;
    logic [31:0] load_val, rollover_val, count_out;
    logic [3:0]  rollover_flag, wrap_pulse, done;

    logic [0:0]  b_zero1, b_en, b_flag, b_wrap, b_done;
    logic [3:0]  b_zero4, b_rv, b_cnt;

    logic [5:0]  c_zero6, c_en, c_flag, c_wrap, c_done;
    logic [47:0] c_zero48, c_rv, c_cnt;

    int checks = 0;
    int errors = 0;

    multi_flex_counter #(.NUM_CNT_BITS(8), .NUM_CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable), .load(load),
        .load_val(load_val), .rollover_val(rollover_val), .one_shot(one_shot),
        .cascade_en(cascade_en), .count_out(count_out), .rollover_flag(rollover_flag),
        .wrap_pulse(wrap_pulse), .done(done)
    );

    multi_flex_counter #(.NUM_CNT_BITS(4), .NUM_CHANNELS(1)) dut_b (
        .clk(clk), .rst(rst), .clear(b_zero1), .count_enable(b_en), .load(b_zero1),
        .load_val(b_zero4), .rollover_val(b_rv), .one_shot(b_zero1),
        .cascade_en(b_zero1), .count_out(b_cnt), .rollover_flag(b_flag),
        .wrap_pulse(b_wrap), .done(b_done)
    );

    multi_flex_counter #(.NUM_CNT_BITS(8), .NUM_CHANNELS(6)) dut_c (
        .clk(clk), .rst(rst), .clear(c_zero6), .count_enable(c_en), .load(c_zero6),
        .load_val(c_zero48), .rollover_val(c_rv), .one_shot(c_zero6),
        .cascade_en(c_zero6), .count_out(c_cnt), .rollover_flag(c_flag),
        .wrap_pulse(c_wrap), .done(c_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt(input int ch);
        return count_out[ch*8 +: 8];
    endfunction

    int wrap_cnt[5]    = '{1, 2, 3, 1, 2};
    int casc_cnt[9]    = '{0, 0, 1, 1, 2, 2, 3, 3, 1};
    int iso_cnt[6]     = '{1, 2, 3, 2, 1, 6};

    initial begin
        rst = 1'b1;
        clear = '0; count_enable = '0; load = '0; one_shot = '0; cascade_en = '0;
        load_val = '0; rollover_val = '0;
        b_zero1 = '0; b_zero4 = '0; b_en = '0; b_rv = '0;
        c_zero6 = '0; c_zero48 = '0; c_en = '0; c_rv = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_count", count_out, 32'd0);
        check_val("reset_flags", {rollover_flag, wrap_pulse, done}, 32'd0);
        rst = 1'b0;

        // basic wrap on ch0, 4-bit single-channel instance and 6-channel isolation
        rollover_val[7:0] = 8'd3;
        count_enable[0]   = 1'b1;
        b_rv = 4'd3; b_en = 1'b1;
        c_rv = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        c_en = 6'h3f;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val($sformatf("wrap_cnt[%0d]", k), cnt(0), wrap_cnt[k]);
            check_val($sformatf("wrap_flag[%0d]", k), rollover_flag[0], (k == 2));
            check_val($sformatf("wrap_pulse[%0d]", k), wrap_pulse[0], (k == 3));
            check_val($sformatf("w4_cnt[%0d]", k), b_cnt, wrap_cnt[k]);
        end
        tick();
        c_en = '0;
        for (int i = 0; i < 6; i++)
            check_val($sformatf("iso_cnt[%0d]", i), c_cnt[i*8 +: 8], iso_cnt[i]);
        check_val("iso_wrap", c_wrap, 6'b010001);
        check_val("iso_flag", c_flag, 6'b100111);

        // asynchronous reset mid-count
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_count", count_out, 32'd0);
        check_val("async_rst_flags", {rollover_flag, wrap_pulse, done}, 32'd0);
        check_val("async_rst_w4", b_cnt, 4'd0);
        @(posedge clk);
        #1;
        count_enable = '0; b_en = 1'b0;
        rst = 1'b0;

        // one-shot on ch1
        rollover_val[15:8] = 8'd5;
        one_shot[1]        = 1'b1;
        count_enable       = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val($sformatf("os_cnt[%0d]", k), cnt(1), (k < 5) ? k + 1 : 5);
            check_val($sformatf("os_done[%0d]", k), done[1], (k >= 4));
            check_val($sformatf("os_flag[%0d]", k), rollover_flag[1], (k >= 4));
            check_val($sformatf("os_wrap[%0d]", k), wrap_pulse[1], 1'b0);
        end
        count_enable = '0;
        clear[1]     = 1'b1;
        tick();
        check_val("os_clear_cnt", cnt(1), 8'd0);
        check_val("os_clear_done", done[1], 1'b0);
        check_val("os_clear_flag", rollover_flag[1], 1'b0);
        clear = '0; one_shot = '0;

        // cascade ch0 -> ch1
        rollover_val[7:0]  = 8'd2;
        rollover_val[15:8] = 8'd3;
        cascade_en[1]      = 1'b1;
        count_enable       = 4'b0011;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_val($sformatf("casc_cnt[%0d]", k), cnt(1), casc_cnt[k]);
            check_val($sformatf("casc_wrap[%0d]", k), wrap_pulse[1], (k == 8));
        end
        count_enable = '0; cascade_en = '0;

        // priority on ch2
        rollover_val[23:16] = 8'd4;
        count_enable        = 4'b0100;
        tick();
        tick();
        check_val("pri_pre_cnt", cnt(2), 8'd2);
        clear[2] = 1'b1; load[2] = 1'b1; load_val[23:16] = 8'd7;
        tick();
        check_val("pri_clear_cnt", cnt(2), 8'd0);
        check_val("pri_clear_wrap", wrap_pulse[2], 1'b0);
        clear[2] = 1'b0;
        tick();
        check_val("pri_load_cnt", cnt(2), 8'd7);
        check_val("pri_load_flag", rollover_flag[2], 1'b0);
        load_val[23:16] = 8'd9;
        tick();
        check_val("pri_load9_cnt", cnt(2), 8'd9);
        load[2] = 1'b0;
        tick();
        check_val("pri_above_cnt", cnt(2), 8'd1);
        check_val("pri_above_wrap", wrap_pulse[2], 1'b1);
        count_enable = '0;

        // boundaries on ch3: rollover_val 0 and 255
        rollover_val[31:24] = 8'd0;
        count_enable        = 4'b1000;
        repeat (3) tick();
        check_val("rv0_cnt", cnt(3), 8'd0);
        check_val("rv0_flags", {rollover_flag[3], wrap_pulse[3], done[3]}, 3'b000);
        load[3] = 1'b1; load_val[31:24] = 8'd5;
        tick();
        load[3] = 1'b0;
        tick();
        tick();
        check_val("rv0_load_hold", cnt(3), 8'd5);
        rollover_val[31:24] = 8'd255;
        load[3] = 1'b1; load_val[31:24] = 8'd254;
        tick();
        check_val("rv255_load", cnt(3), 8'd254);
        load[3] = 1'b0;
        tick();
        check_val("rv255_cnt", cnt(3), 8'd255);
        check_val("rv255_flag", rollover_flag[3], 1'b1);
        tick();
        check_val("rv255_wrap_cnt", cnt(3), 8'd1);
        check_val("rv255_wrap", wrap_pulse[3], 1'b1);
        count_enable = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
